// File: rtl/seg7_reader.sv
// Active-low 7-segment pattern to hex digit decoder with a stability filter; optional SEG7_ERR_COUNT_EN adds err_count.
// Latency: result registered on the edge that takes the STABLE-th identical sample.
// Backpressure: one-entry output buffer; an emit into a full, undrained buffer is dropped and pulses overrun.
module seg7_reader #(
    parameter int STABLE = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] seg,
    input  logic       seg_valid,
    output logic [3:0] digit,
    output logic       err,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       overrun
`ifdef SEG7_ERR_COUNT_EN
    ,
    output logic [7:0] err_count
`endif
);

    localparam logic [7:0] STABLE_L = 8'(STABLE);

    typedef enum logic {IDLE, COUNT} state_t;

    state_t     state, state_nxt;
    logic [6:0] cand, cand_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic [6:0] last;
    logic       last_ok;
    logic       accept;
    logic [6:0] acc_pat;
    logic [4:0] dec;
    logic       emit;
    logic       load;

    // Returns {err, digit}; illegal glyphs decode to err=1, digit=0.
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'h40:   decode = {1'b0, 4'h0};
            7'h79:   decode = {1'b0, 4'h1};
            7'h24:   decode = {1'b0, 4'h2};
            7'h30:   decode = {1'b0, 4'h3};
            7'h19:   decode = {1'b0, 4'h4};
            7'h12:   decode = {1'b0, 4'h5};
            7'h02:   decode = {1'b0, 4'h6};
            7'h78:   decode = {1'b0, 4'h7};
            7'h00:   decode = {1'b0, 4'h8};
            7'h10:   decode = {1'b0, 4'h9};
            7'h08:   decode = {1'b0, 4'hA};
            7'h03:   decode = {1'b0, 4'hB};
            7'h46:   decode = {1'b0, 4'hC};
            7'h21:   decode = {1'b0, 4'hD};
            7'h06:   decode = {1'b0, 4'hE};
            7'h0E:   decode = {1'b0, 4'hF};
            default: decode = {1'b1, 4'h0};
        endcase
    endfunction

    always_comb begin
        state_nxt = state;
        cand_nxt  = cand;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        acc_pat   = cand;
        if (seg_valid) begin
            if (state == IDLE || seg != cand) begin
                state_nxt = COUNT;
                cand_nxt  = seg;
                cnt_nxt   = 8'd1;
                if (STABLE == 1) begin
                    accept  = 1'b1;
                    acc_pat = seg;
                end
            end else begin
                cnt_nxt = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
                // Fires only on the transition into STABLE, so a long run accepts once.
                if (cnt != STABLE_L && cnt_nxt == STABLE_L) begin
                    accept = 1'b1;
                end
            end
        end
    end

    assign dec  = decode(acc_pat);
    assign emit = accept && !(last_ok && acc_pat == last);
    assign load = emit && (!out_valid || out_ready);

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            cand      <= 7'd0;
            cnt       <= 8'd0;
            last      <= 7'd0;
            last_ok   <= 1'b0;
            digit     <= 4'd0;
            err       <= 1'b0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state <= state_nxt;
            cand  <= cand_nxt;
            cnt   <= cnt_nxt;
            if (emit) begin
                last    <= acc_pat;
                last_ok <= 1'b1;
            end
            if (load) begin
                err   <= dec[4];
                digit <= dec[3:0];
            end
            out_valid <= load || (out_valid && !out_ready);
            overrun   <= emit && !load;
        end
    end

`ifdef SEG7_ERR_COUNT_EN
    // Counts every illegal-glyph emission, including ones lost to overrun.
    always_ff @(posedge clock) begin
        if (reset) begin
            err_count <= 8'd0;
        end else if (emit && dec[4] && err_count != 8'hFF) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_seg7_reader.sv
// Directed bench for seg7_reader: scoreboard of expected {err,digit} popped on each output handshake.
module tb_seg7_reader;

    logic       clock = 1'b0;
    logic       reset;
    logic [6:0] seg;
    logic       seg_valid;
    logic [3:0] digit;
    logic       err;
    logic       out_valid;
    logic       out_ready;
    logic       overrun;
`ifdef SEG7_ERR_COUNT_EN
    logic [7:0] err_count;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    int n_emit   = 0;
    int n_ovr    = 0;
    logic [4:0] exp_q[$];

    seg7_reader #(.STABLE(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .seg       (seg),
        .seg_valid (seg_valid),
        .digit     (digit),
        .err       (err),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overrun   (overrun)
`ifdef SEG7_ERR_COUNT_EN
        ,
        .err_count (err_count)
`endif
    );

    always #5 clock = ~clock;

    // Output monitor: handshake completes on the next rising edge.
    always @(negedge clock) begin
        if (!reset && overrun) n_ovr++;
        if (!reset && out_valid && out_ready) begin
            logic [4:0] exp_v;
            n_emit++;
            n_assert++;
            assert (exp_q.size() > 0) else begin
                n_fail++;
                $error("FAIL unexpected_emit: observed err=%0d digit=%0h, required none", err, digit);
            end
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                n_assert++;
                assert ({err, digit} === exp_v) else begin
                    n_fail++;
                    $error("FAIL emit_value: observed err=%0d digit=%0h, required err=%0d digit=%0h",
                           err, digit, exp_v[4], exp_v[3:0]);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, required %0h", tag, obs, expv);
        end
    endtask

    task automatic samples(input logic [6:0] s, input int n);
        for (int i = 0; i < n; i++) begin
            seg       = s;
            seg_valid = 1'b1;
            @(posedge clock);
            #1;
        end
        seg_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        seg_valid = 1'b0;
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        seg       = 7'h7F;
        seg_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        do_reset();

        check("reset_out_valid", {7'd0, out_valid}, 8'd0);
        check("reset_digit", {4'd0, digit}, 8'd0);
        check("reset_err", {7'd0, err}, 8'd0);
        check("reset_overrun", {7'd0, overrun}, 8'd0);
`ifdef SEG7_ERR_COUNT_EN
        check("reset_err_count", err_count, 8'd0);
`endif

        // Basic decode and latency: valid right after the 4th sample's edge.
        samples(7'h24, 3);
        check("early_out_valid", {7'd0, out_valid}, 8'd0);
        exp_q.push_back({1'b0, 4'h2});
        samples(7'h24, 1);
        check("latency_out_valid", {7'd0, out_valid}, 8'd1);
        samples(7'h24, 2);
        idle(3);
        check("single_emit_count", 8'(n_emit), 8'd1);

        // Run restart on a differing sample.
        do_reset();
        samples(7'h24, 3);
        samples(7'h79, 1);
        samples(7'h24, 3);
        idle(2);
        check("restart_no_emit", 8'(n_emit), 8'd1);
        exp_q.push_back({1'b0, 4'h2});
        samples(7'h24, 1);
        idle(3);
        check("restart_emit_count", 8'(n_emit), 8'd2);

        // Illegal glyph then legal F.
        exp_q.push_back({1'b1, 4'h0});
        samples(7'h7F, 4);
        idle(2);
`ifdef SEG7_ERR_COUNT_EN
        check("err_count_one", err_count, 8'd1);
`endif
        exp_q.push_back({1'b0, 4'hF});
        samples(7'h0E, 4);
        idle(2);
        check("err_f_emit_count", 8'(n_emit), 8'd4);

        // Overrun: buffer holds first result, second is dropped.
        out_ready = 1'b0;
        n_ovr = 0;
        exp_q.push_back({1'b0, 4'h0});
        samples(7'h40, 4);
        samples(7'h79, 4);
        idle(3);
        check("overrun_pulses", 8'(n_ovr), 8'd1);
        check("held_out_valid", {7'd0, out_valid}, 8'd1);
        check("held_digit", {4'd0, digit}, 8'd0);
        out_ready = 1'b1;
        idle(4);
        check("drain_emit_count", 8'(n_emit), 8'd5);
        check("drained_out_valid", {7'd0, out_valid}, 8'd0);

        // Alternating glyphs re-emit; repeated glyph across a gap is suppressed.
        exp_q.push_back({1'b0, 4'h5});
        samples(7'h12, 4);
        exp_q.push_back({1'b0, 4'h8});
        samples(7'h00, 4);
        exp_q.push_back({1'b0, 4'h5});
        samples(7'h12, 4);
        idle(3);
        check("alt_emit_count", 8'(n_emit), 8'd8);
        do_reset();
        exp_q.push_back({1'b0, 4'h5});
        samples(7'h12, 4);
        idle(3);
        samples(7'h12, 4);
        idle(3);
        check("gap_suppress_count", 8'(n_emit), 8'd9);

        // Reset mid-count discards partial run.
        samples(7'h30, 3);
        do_reset();
        samples(7'h30, 1);
        idle(3);
        check("post_reset_no_emit", 8'(n_emit), 8'd9);
        exp_q.push_back({1'b0, 4'h3});
        samples(7'h30, 3);
        idle(3);
        check("post_reset_emit", 8'(n_emit), 8'd10);
`ifdef SEG7_ERR_COUNT_EN
        check("err_count_cleared", err_count, 8'd0);
`endif

        check("scoreboard_empty", 8'(exp_q.size()), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_reader.md
# seg7_reader

Inverse of the board's 7-segment hex encoding. Samples an active-low 7-segment pattern bus, requires it to be stable over a programmable number of consecutive samples, then decodes it back to a 4-bit hex digit. The digit is delivered over a valid/ready handshake with a one-entry output buffer. Used as a display-readback self-test monitor beside the HEX drivers, and as a segment-pattern input decoder.

## Interface
- `STABLE`, default 4: consecutive identical samples needed to accept a pattern; legal range 1..255.
- `clock`  in  1: sole clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `seg`  in  7: segment pattern, active-low. Bit 0 = a, bit 1 = b, … bit 6 = g.
- `seg_valid`  in  1: `seg` is a sample this cycle.
- `digit`  out  4: decoded hex value.
- `err`  out  1: the accepted pattern is not a legal hex glyph; `digit` is 0.
- `out_valid`  out  1: `digit`/`err` hold a pending result.
- `out_ready`  in  1: consumer accepts the result when both `out_valid` and `out_ready` are 1.
- `overrun`  out  1: single-cycle pulse when an accepted pattern is dropped.
- `err_count`  out  8: only present with `SEG7_ERR_COUNT_EN`.

## Operation
- Legal glyphs, as hex values of `seg[6:0]`:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
  - Every other pattern is illegal.
- Registers: `cand[6:0]`, `cnt[7:0]`, `last[6:0]`, `last_ok`, plus the output buffer.
- Filter FSM:
  - IDLE: on `seg_valid`, set `cand<=seg` and `cnt<=1`, then go to COUNT. If `STABLE`==1, perform the ACCEPT check in the same cycle.
  - COUNT: on `seg_valid`:
    - If `seg`==`cand`, increment `cnt` (saturating at 255). When `cnt` reaches `STABLE`, perform ACCEPT.
    - If `seg`!=`cand`, set `cand<=seg` and `cnt<=1`.
  - When `seg_valid`=0, state is held.
- ACCEPT happens once per stable run; further identical samples do not re-accept.
  - If `last_ok`=1 and `cand`==`last`: no emission (a repeated glyph is suppressed).
  - Otherwise, set `last<=cand`, `last_ok<=1`, and emit.
- Emit:
  - If the buffer is empty, or is being drained this same cycle (`out_valid`&`out_ready`), load `digit`/`err` and set `out_valid`=1.
  - Otherwise the new result is dropped, `overrun` pulses, and the buffered result is unchanged. `last` still updates.
- `out_valid` clears on handshake unless a new emit loads in that same cycle.

## Timing
- Reset values: `out_valid`=0, `digit`=0, `err`=0, `overrun`=0, `err_count`=0, FSM=IDLE, `cnt`=0, `last_ok`=0.
- Latency: `out_valid` rises on the edge after the `STABLE`-th consecutive identical `seg_valid` sample. For back-to-back valid samples this is `STABLE` cycles after the first sample.
- `digit` and `err` are stable while `out_valid`=1 and not yet accepted.
- Reset asserted mid-count or with a result pending: all state is discarded, and nothing is emitted until a full new stable run completes.

## Configuration
- `SEG7_ERR_COUNT_EN` defined:
  - Adds the `err_count` port: a saturating 8-bit count (stops at 255) of emissions with `err`=1.
  - The count increments on emit, including dropped (overrun) emissions.
  - Cleared by reset.
- `SEG7_ERR_COUNT_EN` undefined: no `err_count` port and no counter logic. All other behaviour is identical.

## Test plan
- `STABLE`=4, `out_ready`=1, `seg`=7'h24 valid for 4 cycles -> one `out_valid` pulse with `digit`=2, `err`=0. A 5th and 6th identical sample produce no further output.
- `seg` sequence 24,24,24,79,24,24,24,24 (all valid) -> the run restarts at 79, and exactly one emission `digit`=2 follows the final sample.
- Stable 7'h7F -> `digit`=0, `err`=1. With `SEG7_ERR_COUNT_EN`, `err_count`=1. Then stable 7'h0E -> `digit`=F, `err`=0.
- `out_ready`=0, stable 40 then stable 79 -> the buffer holds `digit`=0, `overrun` pulses once on the 79 accept, and raising `out_ready` drains exactly one result (`digit`=0).
- Stable 12, then stable 00, then stable 12 -> three emissions: 5, 8, 5. Stable 12 twice with an invalid-sample gap between -> one emission.
- Reset after 3 of 4 matching samples of 30, then 1 more 30 sample -> no emission. A further 3 samples -> `digit`=3.
